// File: rtl/rd_fifo_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module   : rd_fifo_pixel_reader
// Brief    : Raster timing generator that pops one 24-bit pixel per visible
//            clock from a standard (non-FWFT) FIFO, aligned with hsync/vsync/de.
// Revision : 1.0 - initial release
// ============================================================================
module rd_fifo_pixel_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [23:0] fifo_data_rd,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        underflow
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = (c_h_total > 1) ? $clog2(c_h_total) : 1;
    localparam int c_vw      = (c_v_total > 1) ? $clog2(c_v_total) : 1;

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_prime = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_hw-1:0] r_h_cnt;
    logic [c_vw-1:0] r_v_cnt;

    logic w_run;
    logic w_active;
    logic w_pop;
    logic w_starve;
    logic w_hsync_on;
    logic w_vsync_on;
    logic w_first;
    logic w_h_last;
    logic w_v_last;

    logic r_pop_q;
    logic r_de;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;
    logic r_underflow;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; enable is only honoured at the frame boundary while running
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (enable)      w_state_nxt = c_st_prime;
            c_st_prime: if (!fifo_empty) w_state_nxt = c_st_run;
            c_st_run:   if (w_h_last && w_v_last && !enable) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Output / decode logic
    always_comb begin
        w_run      = (r_state == c_st_run);
        w_h_last   = (r_h_cnt == c_h_last);
        w_v_last   = (r_v_cnt == c_v_last);
        w_active   = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
        w_pop      = rst_n && w_run && w_active && !fifo_empty;
        w_starve   = w_run && w_active && fifo_empty;
        w_hsync_on = w_run && (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
        w_vsync_on = w_run && (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
        w_first    = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // Raster counters free-run only in RUN; held at the origin otherwise
    always_ff @(posedge clk) begin
        if (!rst_n || !w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // One-clock pipeline matching the FIFO read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pop_q       <= 1'b0;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_pop_q       <= w_pop;
            r_de          <= w_run && w_active;
            r_hsync       <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_first;
            if (w_starve) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // FIFO output register already holds the popped word; starved or blank slots read black
    assign fifo_rd_en   = w_pop;
    assign fifo_data_rd = r_pop_q ? fifo_dout : 24'h000000;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign de           = r_de;
    assign frame_start  = r_frame_start;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
